// File: rtl/handshake_fixmul_pipe.sv
// Elastic signed fixed-point multiplier that joins two operand channels.
// It computes floor(lhs*rhs / 2^FRAC_BITS), saturates the result, and moves it through a LATENCY-deep stalling pipeline.
module handshake_fixmul_pipe #(
  parameter int DATA_WIDTH = 27,
  parameter int FRAC_BITS  = 24,
  parameter int LATENCY    = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] lhs,
  input  logic                  lhs_valid,
  output logic                  lhs_ready,
  input  logic [DATA_WIDTH-1:0] rhs,
  input  logic                  rhs_valid,
  output logic                  rhs_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  result_valid,
  input  logic                  result_ready
);

  localparam int PW = 2 * DATA_WIDTH;

  // Full signed product, floor shift, then clamp to the signed DATA_WIDTH range.
  function automatic logic [DATA_WIDTH-1:0] fix_mul_sat(
    input logic signed [DATA_WIDTH-1:0] a,
    input logic signed [DATA_WIDTH-1:0] b
  );
    logic signed [PW-1:0]   prod;
    logic signed [PW-1:0]   shifted;
    logic [DATA_WIDTH-1:0]  res;
    prod    = PW'(a) * PW'(b);
    shifted = prod >>> FRAC_BITS;
    if ((&shifted[PW-1:DATA_WIDTH-1]) || (~|shifted[PW-1:DATA_WIDTH-1])) begin
      res = shifted[DATA_WIDTH-1:0];
    end else if (shifted[PW-1]) begin
      res = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    end else begin
      res = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end
    return res;
  endfunction

  logic [LATENCY:1]      v_q;
  logic [DATA_WIDTH-1:0] data_q [1:LATENCY];
  logic [DATA_WIDTH-1:0] data_d;
  logic                  en_s;
  logic                  fire_s;

  // Global stall enable, join handshake and stage-1 arithmetic.
  always_comb begin
    en_s      = (~v_q[LATENCY]) | result_ready;
    fire_s    = en_s & lhs_valid & rhs_valid;
    lhs_ready = en_s & rhs_valid;
    rhs_ready = en_s & lhs_valid;
    data_d    = fix_mul_sat($signed(lhs), $signed(rhs));
  end

  // Pipeline shift. Stage-1 data only loads on fire, so bubbles carry held values instead of X.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q <= '0;
      for (int k = 1; k <= LATENCY; k++) begin
        data_q[k] <= '0;
      end
    end else if (en_s) begin
      v_q[1] <= fire_s;
      if (fire_s) begin
        data_q[1] <= data_d;
      end
      for (int k = 2; k <= LATENCY; k++) begin
        v_q[k]    <= v_q[k-1];
        data_q[k] <= data_q[k-1];
      end
    end
  end

  assign result_valid = v_q[LATENCY];
  assign result       = data_q[LATENCY];

endmodule
